score_keeper: RTL
=================

// Module: score_keeper
// PURPOSE
// - Producer side of the scoreboard stats bus: turns judged note hits into combo, max_combo,
//   base_score, bonus_score, acc and level, which feed the scoreboard display directly.
// - Sits between the note judge (hit_valid/hit_grade handshake) and the display driver.
// - Accuracy is computed by a bit-serial divider, so the block back-pressures the judge while it divides.
// PARAMETERS
// - STAT_W     21   width of every stat output; all saturate at 2^STAT_W-1 (2097151)
// - NUM_W      48   divider numerator width; divide takes exactly NUM_W cycles
// - COMBO_CAP  100  combo value at which the bonus increment stops growing
// PORTS
// - clk          in   1       single clock; every register updates on posedge clk
// - rst          in   1       synchronous, active-high reset
// - start        in   1       1-cycle pulse: clear stats, latch mod/difficulty, enter PLAY
// - finish       in   1       1-cycle pulse: end of song, freeze stats
// - mod_in       in   2       0 none(x1), 1 hard(x2), 2 easy(x1/2), 3 reserved(x1)
// - difficulty_in in  4       song difficulty, 0..15
// - hit_valid    in   1       judge presents a hit
// - hit_grade    in   2       0 miss, 1 good(50), 2 great(100), 3 perfect(300)
// - hit_ready    out  1       high only in PLAY; hit accepted on an edge where valid&ready
// - combo, max_combo, base_score, bonus_score, acc  out STAT_W  stats; acc in 0.01 % (0..10000)
// - level        out  3       0 SS,1 S,2 A,3 B,4 C,5 D,7 unrated
// - mod          out  2       latched mod_in;  difficulty out 4  latched difficulty_in
// - stats_valid  out  1       high in DONE (final stats stable)
// BEHAVIOUR
// - Reset: all stats 0, mod/difficulty 0, level 7, hit_ready 0, stats_valid 0, state IDLE.
// - FSM IDLE -start-> PLAY; PLAY -accepted hit-> DIV; DIV -NUM_W cycles-> PLAY;
//   PLAY -finish-> DONE; DONE -start-> PLAY. start in any state clears and goes to PLAY.
// - start edge: stats, hit count, weighted sum cleared; acc=10000, level=0; mod/difficulty latched
//   (mid-song changes of mod_in/difficulty_in are ignored).
// - Hit accepted at edge N: combo/max_combo/base/bonus/count/weighted sum updated at edge N,
//   divider loaded at edge N; acc and level written at edge N+NUM_W, state back to PLAY at the
//   same edge; hit_ready high again in the following cycle (hit-to-hit minimum NUM_W+1 cycles).
// - Miss: combo<=0, miss flag set; else combo+1. max_combo=max(max_combo,new combo).
// - base += grade weight (unscaled). Non-miss: bonus += scale(min(new combo,COMBO_CAP)*(difficulty+1)),
//   scale by latched mod: x2 = <<1, x1/2 = >>1 (truncate). Miss adds no bonus.
// - acc = floor(weighted_sum*10000 / (count*300)), NUM_W-bit unsigned; count>=1 whenever divided.
// - level from new acc: 10000 ->0; >=9500 and no miss ->1; >=9000 ->2; >=8000 ->3; >=7000 ->4; else 5.
// - Saturation: any stat or internal counter that would exceed 2^STAT_W-1 holds at max.
// - start and hit_valid same edge: start wins, hit not counted. finish and hit same edge in PLAY:
//   hit counted, finish recorded as pending; DONE entered when the divide completes.
// - finish during DIV: pending, DONE after acc written. start during DIV: divide aborted, cleared.
// - rst mid-divide: reset values at that edge, divider result discarded. finish in IDLE/DONE: ignored.
// STRUCTURE
// - Constants.vh: grade codes, grade weights 300/100/50/0, level codes + thresholds, mod codes.
// - Sub-module acc_divider: restoring serial divider (load, NUM_W-cycle busy, done pulse, quotient).
// - Top: FSM, stat registers with saturating adders, level compare, pending-finish flag.
// TESTING
// - start(diff=3,mod=0); 3 perfect -> combo 3, base 900, bonus 24, acc 10000, level 0, max_combo 3.
// - then 1 miss -> combo 0, max_combo 3, base 900, acc 7500 (9000000/1200), level 4.
// - start(diff=0,mod=1); perfect+good -> bonus 2+4=6, base 350, acc 5833, level 5.
// - 150 perfects diff=0 mod=0 -> bonus increments capped at 100 from hit 100 on; hit_ready low
//   exactly NUM_W cycles after each accept.
// - finish asserted mid-DIV -> stats_valid rises the cycle after acc is written; later hits ignored.
// - rst asserted during DIV, and start+hit same edge -> reset values / cleared stats, hit not counted.

Source files
------------

// File: rtl/score_keeper_pkg.sv
// Shared constants, state encoding and small arithmetic helpers for the score keeper.
// Grade weights, level thresholds and mod codes live here so the top and bench agree.
package score_keeper_pkg;

    localparam int STAT_W    = 21;
    localparam int NUM_W     = 48;
    localparam int COMBO_CAP = 100;
    localparam int ACC_SCALE = 10000;
    localparam int PERFECT_W = 300;

    localparam logic [STAT_W-1:0] STAT_MAX = {STAT_W{1'b1}};

    localparam logic [1:0] GRADE_MISS    = 2'd0;
    localparam logic [1:0] GRADE_GOOD    = 2'd1;
    localparam logic [1:0] GRADE_GREAT   = 2'd2;
    localparam logic [1:0] GRADE_PERFECT = 2'd3;

    localparam logic [1:0] MOD_NONE = 2'd0;
    localparam logic [1:0] MOD_HARD = 2'd1;
    localparam logic [1:0] MOD_EASY = 2'd2;

    localparam logic [2:0] LVL_SS      = 3'd0;
    localparam logic [2:0] LVL_S       = 3'd1;
    localparam logic [2:0] LVL_A       = 3'd2;
    localparam logic [2:0] LVL_B       = 3'd3;
    localparam logic [2:0] LVL_C       = 3'd4;
    localparam logic [2:0] LVL_D       = 3'd5;
    localparam logic [2:0] LVL_UNRATED = 3'd7;

    localparam logic [STAT_W-1:0] ACC_FULL = 21'd10000;
    localparam logic [STAT_W-1:0] THR_S    = 21'd9500;
    localparam logic [STAT_W-1:0] THR_A    = 21'd9000;
    localparam logic [STAT_W-1:0] THR_B    = 21'd8000;
    localparam logic [STAT_W-1:0] THR_C    = 21'd7000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    function automatic logic [STAT_W-1:0] grade_weight(input logic [1:0] g);
        case (g)
            GRADE_PERFECT: return 21'd300;
            GRADE_GREAT:   return 21'd100;
            GRADE_GOOD:    return 21'd50;
            default:       return 21'd0;
        endcase
    endfunction

    function automatic logic [STAT_W-1:0] sat_add(input logic [STAT_W-1:0] a,
                                                  input logic [STAT_W-1:0] b);
        logic [STAT_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[STAT_W] ? STAT_MAX : s[STAT_W-1:0];
    endfunction

    // The S grade additionally demands a miss-free run.
    function automatic logic [2:0] level_of(input logic [STAT_W-1:0] a, input logic missed);
        if (a == ACC_FULL)             return LVL_SS;
        else if (a >= THR_S && !missed) return LVL_S;
        else if (a >= THR_A)           return LVL_A;
        else if (a >= THR_B)           return LVL_B;
        else if (a >= THR_C)           return LVL_C;
        else                           return LVL_D;
    endfunction

endpackage

// File: rtl/score_keeper_acc_divider.sv
// Restoring bit-serial divider: load, then exactly W busy cycles, one quotient bit per cycle.
// done_o and quo_o are combinational during the final step so the result lands on the W-th edge.
module acc_divider #(
    parameter int W = 48
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic         abort_i,
    input  logic [W-1:0] num_i,
    input  logic [W-1:0] den_i,
    output logic         done_o,
    output logic [W-1:0] quo_o
);

    localparam int CNT_W = $clog2(W + 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(W);

    logic [W-1:0]     rem_q, quo_q, den_q;
    logic [W-1:0]     rem_d, quo_d;
    logic [CNT_W-1:0] cnt_q;
    logic             busy_q;
    logic [W:0]       trial, diff;
    logic             fits;

    always_comb begin
        trial  = {rem_q, quo_q[W-1]};
        diff   = trial - {1'b0, den_q};
        fits   = (trial >= {1'b0, den_q});
        rem_d  = fits ? diff[W-1:0] : trial[W-1:0];
        quo_d  = {quo_q[W-2:0], fits};
        done_o = busy_q && (cnt_q == CNT_ONE);
        quo_o  = quo_d;
    end

    always_ff @(posedge clk) begin
        if (rst || abort_i) begin
            rem_q  <= '0;
            quo_q  <= '0;
            den_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else if (load_i) begin
            rem_q  <= '0;
            quo_q  <= num_i;
            den_q  <= den_i;
            cnt_q  <= CNT_LOAD;
            busy_q <= 1'b1;
        end else if (busy_q) begin
            rem_q  <= rem_d;
            quo_q  <= quo_d;
            cnt_q  <= cnt_q - CNT_ONE;
            busy_q <= (cnt_q != CNT_ONE);
        end
    end

endmodule

// File: rtl/score_keeper.sv
// Turns judged note hits into combo, score, accuracy and level for the scoreboard display.
// hit_valid/hit_ready: a hit transfers on a rising edge where both are high; ready is only high in PLAY.
module score_keeper
    import score_keeper_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              finish,
    input  logic [1:0]        mod_in,
    input  logic [3:0]        difficulty_in,
    input  logic              hit_valid,
    input  logic [1:0]        hit_grade,
    output logic              hit_ready,
    output logic [STAT_W-1:0] combo,
    output logic [STAT_W-1:0] max_combo,
    output logic [STAT_W-1:0] base_score,
    output logic [STAT_W-1:0] bonus_score,
    output logic [STAT_W-1:0] acc,
    output logic [2:0]        level,
    output logic [1:0]        mod,
    output logic [3:0]        difficulty,
    output logic              stats_valid,
    output logic [1:0]        dbg_state
);

    state_e            state_q, state_d;
    logic [STAT_W-1:0] combo_q, max_q, base_q, bonus_q, acc_q, count_q;
    logic [2:0]        level_q;
    logic [1:0]        mod_q;
    logic [3:0]        diff_q;
    logic              miss_q, fin_pend_q;

    logic              accept, div_done;
    logic              is_miss;
    logic [STAT_W-1:0] weight, combo_new, max_new, base_new, bonus_new, count_new, acc_new;
    logic [6:0]        cap7;
    logic [4:0]        mult;
    logic [11:0]       prod;
    logic [12:0]       inc;
    logic [NUM_W-1:0]  div_num, div_den, div_quo;

    assign accept = (state_q == ST_PLAY) && hit_valid && !start;

    always_comb begin
        state_d   = state_q;
        hit_ready = (state_q == ST_PLAY);
        if (start) begin
            state_d = ST_PLAY;
        end else begin
            case (state_q)
                ST_PLAY: begin
                    if (hit_valid)   state_d = ST_DIV;
                    else if (finish) state_d = ST_DONE;
                end
                ST_DIV: begin
                    if (div_done) state_d = (fin_pend_q || finish) ? ST_DONE : ST_PLAY;
                end
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // base_score doubles as the weighted sum of grade weights feeding the accuracy divide.
    always_comb begin
        is_miss   = (hit_grade == GRADE_MISS);
        weight    = grade_weight(hit_grade);
        combo_new = is_miss ? '0 : sat_add(combo_q, STAT_W'(1));
        max_new   = (combo_new > max_q) ? combo_new : max_q;
        cap7      = (combo_new > STAT_W'(COMBO_CAP)) ? 7'(COMBO_CAP) : combo_new[6:0];
        mult      = {1'b0, diff_q} + 5'd1;
        prod      = {5'b0, cap7} * {7'b0, mult};
        case (mod_q)
            MOD_HARD: inc = {prod, 1'b0};
            MOD_EASY: inc = {2'b0, prod[11:1]};
            default:  inc = {1'b0, prod};
        endcase
        bonus_new = is_miss ? bonus_q : sat_add(bonus_q, {{(STAT_W-13){1'b0}}, inc});
        base_new  = sat_add(base_q, weight);
        count_new = sat_add(count_q, STAT_W'(1));
        div_num   = {{(NUM_W-STAT_W){1'b0}}, base_new} * NUM_W'(ACC_SCALE);
        div_den   = {{(NUM_W-STAT_W){1'b0}}, count_new} * NUM_W'(PERFECT_W);
        acc_new   = (|div_quo[NUM_W-1:STAT_W]) ? STAT_MAX : div_quo[STAT_W-1:0];
    end

    acc_divider #(.W(NUM_W)) u_div (
        .clk     (clk),
        .rst     (rst),
        .load_i  (accept),
        .abort_i (start),
        .num_i   (div_num),
        .den_i   (div_den),
        .done_o  (div_done),
        .quo_o   (div_quo)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            combo_q    <= '0;
            max_q      <= '0;
            base_q     <= '0;
            bonus_q    <= '0;
            count_q    <= '0;
            acc_q      <= '0;
            level_q    <= LVL_UNRATED;
            mod_q      <= MOD_NONE;
            diff_q     <= '0;
            miss_q     <= 1'b0;
            fin_pend_q <= 1'b0;
        end else if (start) begin
            combo_q    <= '0;
            max_q      <= '0;
            base_q     <= '0;
            bonus_q    <= '0;
            count_q    <= '0;
            acc_q      <= ACC_FULL;
            level_q    <= LVL_SS;
            mod_q      <= mod_in;
            diff_q     <= difficulty_in;
            miss_q     <= 1'b0;
            fin_pend_q <= 1'b0;
        end else begin
            if (accept) begin
                combo_q <= combo_new;
                max_q   <= max_new;
                base_q  <= base_new;
                bonus_q <= bonus_new;
                count_q <= count_new;
                if (is_miss) miss_q <= 1'b1;
            end
            if ((state_q == ST_DIV) && div_done) begin
                acc_q   <= acc_new;
                level_q <= level_of(acc_new, miss_q);
            end
            if (state_d == ST_DONE)
                fin_pend_q <= 1'b0;
            else if (finish && (accept || (state_q == ST_DIV)))
                fin_pend_q <= 1'b1;
        end
    end

    assign combo       = combo_q;
    assign max_combo   = max_q;
    assign base_score  = base_q;
    assign bonus_score = bonus_q;
    assign acc         = acc_q;
    assign level       = level_q;
    assign mod         = mod_q;
    assign difficulty  = diff_q;
    assign stats_valid = (state_q == ST_DONE);
    assign dbg_state   = state_q;

endmodule
